// File: rtl/int_to_float_seq_pkg.sv
// ============================================================================
// Module  : int_to_float_seq_pkg
// Brief   : Shared float header: field widths, exponent bias and rounding
//           mode constants for the integer-to-float converter family.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package int_to_float_seq_pkg;

   localparam logic FLOAT_ROUND_TRUNC   = 1'b0;
   localparam logic FLOAT_ROUND_NEAREST = 1'b1;

   // Exponent field width for the supported float formats (16/32/64).
   function automatic int exponent_size(input int float_size);
      case (float_size)
         16:      return 5;
         64:      return 11;
         default: return 8;
      endcase
   endfunction

   // Stored mantissa width (hidden bit excluded).
   function automatic int mantissa_size(input int float_size);
      return float_size - exponent_size(float_size) - 1;
   endfunction

   // Exponent bias, 2^(E-1)-1.
   function automatic int exponent_biais(input int float_size);
      return (1 << (exponent_size(float_size) - 1)) - 1;
   endfunction

   // Width of the unbiased exponent counter: must hold 0 .. int_size.
   function automatic int exp_counter_size(input int int_size);
      return $clog2(int_size + 1);
   endfunction

endpackage

`default_nettype wire

// File: rtl/int_to_float_seq_float_round.sv
// ============================================================================
// Module  : float_round
// Brief   : Combinational rounding/packing of a normalised magnitude into an
//           IEEE-style float, with saturation to infinity on overflow.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module float_round
   import int_to_float_seq_pkg::*;
#(
   parameter int int_size   = 16,
   parameter int float_size = 32,
   parameter int EXP_W      = exp_counter_size(int_size)
) (
   input  logic [int_size-1:0]   mag,
   input  logic [EXP_W-1:0]      exp,
   input  logic                  sign,
   input  logic                  round_mode,
   output logic [float_size-1:0] float_out,
   output logic                  overflow,
   output logic                  inexact
);

   localparam int E   = exponent_size(float_size);
   localparam int M   = mantissa_size(float_size);
   localparam int B   = exponent_biais(float_size);
   // Magnitude is widened on the right so guard always exists.
   localparam int W   = (int_size > M + 2) ? int_size : M + 2;
   localparam int PAD = W - int_size;
   // Bit position of the guard bit; everything below it is sticky.
   localparam int LOW = W - 2 - M;
   localparam logic [31:0] B_U = B;

   logic [W-1:0] ext;
   logic [M-1:0] frac;
   logic         guard;
   logic         sticky;
   logic         inc;
   logic [M:0]   frac_sum;
   logic [31:0]  exp_ext;
   logic [E-1:0] exp_biased;

   // Extract fraction/guard/sticky, round, then pack or saturate.
   always_comb begin
      ext        = W'(mag) << PAD;
      frac       = ext[W-2 -: M];
      guard      = ext[LOW];
      sticky     = |(ext & ((W'(1) << LOW) - W'(1)));
      inc        = (round_mode == FLOAT_ROUND_NEAREST) & guard & (sticky | frac[0]);
      frac_sum   = {1'b0, frac} + (M+1)'(inc);
      // A carry out of the fraction leaves frac_sum[M-1:0] at zero already.
      exp_ext    = 32'(exp) + 32'(frac_sum[M]);
      exp_biased = E'(exp_ext + B_U);
      inexact    = guard | sticky;
      overflow   = (exp_ext > B_U);
      if (overflow) begin
         float_out = {sign, {E{1'b1}}, {M{1'b0}}};
      end else begin
         float_out = {sign, exp_biased, frac_sum[M-1:0]};
      end
   end

endmodule

`default_nettype wire

// File: rtl/int_to_float_seq.sv
// ============================================================================
// Module  : int_to_float_seq
// Brief   : Sequential integer-to-float converter. Absolute value, one-bit-
//           per-cycle normalisation, then rounding; valid/ready on both sides.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module int_to_float_seq
   import int_to_float_seq_pkg::*;
#(
   parameter int int_size   = 16,
   parameter int float_size = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [int_size-1:0]   int_in,
   input  logic                  signed_mode,
   input  logic                  round_mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [float_size-1:0] float_out,
   output logic                  overflow,
   output logic                  inexact
);

   localparam int EXP_W = exp_counter_size(int_size);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ABS   = 3'd1,
      S_NORM  = 3'd2,
      S_ROUND = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t                state_q, state_d;
   logic [int_size-1:0]   mag_q, mag_d;
   logic [EXP_W-1:0]      exp_q, exp_d;
   logic                  sign_q, sign_d;
   logic                  signed_q, signed_d;
   logic                  round_q, round_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [float_size-1:0] float_q, float_d;
   logic                  overflow_q, overflow_d;
   logic                  inexact_q, inexact_d;

   logic [float_size-1:0] rnd_float;
   logic                  rnd_overflow;
   logic                  rnd_inexact;

   float_round #(
      .int_size   (int_size),
      .float_size (float_size),
      .EXP_W      (EXP_W)
   ) u_float_round (
      .mag        (mag_q),
      .exp        (exp_q),
      .sign       (sign_q),
      .round_mode (round_q),
      .float_out  (rnd_float),
      .overflow   (rnd_overflow),
      .inexact    (rnd_inexact)
   );

   // Next-state and datapath update for the conversion sequence.
   always_comb begin
      state_d     = state_q;
      mag_d       = mag_q;
      exp_d       = exp_q;
      sign_d      = sign_q;
      signed_d    = signed_q;
      round_d     = round_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      float_d     = float_q;
      overflow_d  = overflow_q;
      inexact_d   = inexact_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid && in_ready_q) begin
               // Raw operand parks in mag until ABS resolves the sign.
               mag_d      = int_in;
               signed_d   = signed_mode;
               round_d    = round_mode;
               in_ready_d = 1'b0;
               state_d    = S_ABS;
            end
         end
         S_ABS: begin
            sign_d = signed_q & mag_q[int_size-1];
            mag_d  = sign_d ? (~mag_q + int_size'(1)) : mag_q;
            exp_d  = EXP_W'(int_size - 1);
            if (mag_d == '0) begin
               float_d     = '0;
               overflow_d  = 1'b0;
               inexact_d   = 1'b0;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end else if (mag_d[int_size-1]) begin
               state_d = S_ROUND;
            end else begin
               state_d = S_NORM;
            end
         end
         S_NORM: begin
            mag_d = mag_q << 1;
            exp_d = exp_q - EXP_W'(1);
            if (mag_q[int_size-2]) begin
               state_d = S_ROUND;
            end
         end
         S_ROUND: begin
            float_d     = rnd_float;
            overflow_d  = rnd_overflow;
            inexact_d   = rnd_inexact;
            out_valid_d = 1'b1;
            state_d     = S_DONE;
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               in_ready_d  = 1'b1;
               state_d     = S_IDLE;
            end
         end
         default: begin
            in_ready_d  = 1'b1;
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   // State and output registers; asynchronous reset aborts any conversion.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         mag_q       <= '0;
         exp_q       <= '0;
         sign_q      <= 1'b0;
         signed_q    <= 1'b0;
         round_q     <= FLOAT_ROUND_TRUNC;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         float_q     <= '0;
         overflow_q  <= 1'b0;
         inexact_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         mag_q       <= mag_d;
         exp_q       <= exp_d;
         sign_q      <= sign_d;
         signed_q    <= signed_d;
         round_q     <= round_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         float_q     <= float_d;
         overflow_q  <= overflow_d;
         inexact_q   <= inexact_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = out_valid_q;
   assign float_out = float_q;
   assign overflow  = overflow_q;
   assign inexact   = inexact_q;

endmodule

`default_nettype wire

// File: tb/tb_int_to_float_seq.sv
// ============================================================================
// Module  : tb_int_to_float_seq
// Brief   : Self-checking bench for int_to_float_seq across three
//           configurations (16->32, 32->32, 32->16).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_int_to_float_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] din;
   logic        sm, rm, ordy;
   logic [2:0]  iv, ir, ov, of, ix;
   logic [31:0] fo_a, fo_b;
   logic [15:0] fo_c;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   int_to_float_seq #(.int_size(16), .float_size(32)) u_a (
      .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(ir[0]),
      .int_in(din[15:0]), .signed_mode(sm), .round_mode(rm),
      .out_valid(ov[0]), .out_ready(ordy), .float_out(fo_a),
      .overflow(of[0]), .inexact(ix[0]));

   int_to_float_seq #(.int_size(32), .float_size(32)) u_b (
      .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(ir[1]),
      .int_in(din), .signed_mode(sm), .round_mode(rm),
      .out_valid(ov[1]), .out_ready(ordy), .float_out(fo_b),
      .overflow(of[1]), .inexact(ix[1]));

   int_to_float_seq #(.int_size(32), .float_size(16)) u_c (
      .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(ir[2]),
      .int_in(din), .signed_mode(sm), .round_mode(rm),
      .out_valid(ov[2]), .out_ready(ordy), .float_out(fo_c),
      .overflow(of[2]), .inexact(ix[2]));

   function automatic logic [31:0] get_fo(input int sel);
      case (sel)
         0:       return fo_a;
         1:       return fo_b;
         default: return {16'h0, fo_c};
      endcase
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference conversion from plain integer arithmetic.
   function automatic longint unsigned model(input int sel, input logic [31:0] v,
                                             input logic s, input logic r,
                                             output bit ovf, output bit inx,
                                             output int lat);
      int isz = (sel == 0) ? 16 : 32;
      int fs  = (sel == 2) ? 16 : 32;
      int m   = (fs == 16) ? 10 : 23;
      int e_w = (fs == 16) ? 5 : 8;
      int b   = (fs == 16) ? 15 : 127;
      longint unsigned raw, mag, q, rem, half, res;
      bit neg;
      int e, sh;
      raw = longint'(v) & ((64'd1 << isz) - 1);
      neg = s && raw[isz-1];
      mag = neg ? ((64'd1 << isz) - raw) : raw;
      ovf = 0;
      inx = 0;
      if (mag == 0) begin
         lat = 1;
         return 0;
      end
      e = 0;
      while ((mag >> (e + 1)) != 0) e++;
      lat = 2 + (isz - 1 - e);
      if (e <= m) begin
         q = mag << (m - e);
      end else begin
         sh   = e - m;
         q    = mag >> sh;
         rem  = mag - (q << sh);
         half = 64'd1 << (sh - 1);
         inx  = (rem != 0);
         if (r && ((rem > half) || (rem == half && q[0]))) q++;
         if (q == (64'd1 << (m + 1))) begin
            q = q >> 1;
            e++;
         end
      end
      res = longint'(neg) << (fs - 1);
      if (e > b) begin
         ovf = 1;
         res = res | (((64'd1 << e_w) - 1) << m);
      end else begin
         res = res | (longint'(e + b) << m) | (q & ((64'd1 << m) - 1));
      end
      return res;
   endfunction

   // One full transaction: accept, wait for result, optional back-pressure, drain.
   task automatic run(input int sel, input logic [31:0] v, input logic s, input logic r,
                      input bit use_want, input logic [63:0] want,
                      input int hold, input bit noise);
      bit             e_ovf, e_inx;
      int             e_lat, cyc;
      longint unsigned e_res;
      logic [31:0]    held;
      e_res = model(sel, v, s, r, e_ovf, e_inx, e_lat);
      if (use_want) e_res = want;
      @(negedge clk);
      din = v; sm = s; rm = r; ordy = 1'b0; iv = '0; iv[sel] = 1'b1;
      chk("in_ready_idle", ir[sel], 1'b1);
      @(posedge clk); #1;
      iv = '0;
      if (noise) begin
         din = $urandom; sm = 1'($urandom_range(0, 1)); rm = 1'($urandom_range(0, 1));
      end
      cyc = 0;
      while (!ov[sel] && cyc < 100) begin
         if (noise) begin
            iv[sel] = 1'($urandom_range(0, 1));
            din = $urandom;
         end
         @(posedge clk); #1;
         cyc++;
      end
      iv = '0;
      chk($sformatf("latency v=%0h", v), cyc, e_lat);
      chk($sformatf("float v=%0h", v), get_fo(sel), e_res);
      chk($sformatf("overflow v=%0h", v), of[sel], e_ovf);
      chk($sformatf("inexact v=%0h", v), ix[sel], e_inx);
      if (hold > 0) begin
         held = get_fo(sel);
         repeat (hold) begin @(posedge clk); #1; end
         chk("hold_valid", ov[sel], 1'b1);
         chk("hold_float", get_fo(sel), held);
         chk("hold_in_ready", ir[sel], 1'b0);
      end
      ordy = 1'b1;
      @(posedge clk); #1;
      ordy = 1'b0;
      chk("drain_in_ready", ir[sel], 1'b1);
      chk("drain_out_valid", ov[sel], 1'b0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] v;
      reset = 1'b0; din = '0; sm = 1'b0; rm = 1'b0; ordy = 1'b0; iv = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_in_ready", ir, 3'b111);
      chk("reset_out_valid", ov, 3'b000);
      chk("reset_flags", {of, ix}, 6'b0);
      chk("reset_float", {fo_a, fo_b, fo_c}, 80'h0);
      @(negedge clk);
      reset = 1'b1;

      // 16 -> 32 directed
      run(0, 32'h0001, 1, 1, 1, 64'h3F800000, 0, 0);
      run(0, 32'hFFFF, 1, 1, 1, 64'hBF800000, 0, 0);
      run(0, 32'h8000, 1, 1, 1, 64'hC7000000, 0, 0);
      run(0, 32'h0000, 1, 1, 1, 64'h00000000, 0, 0);
      run(0, 32'hFFFF, 0, 1, 1, 64'h477FFF00, 0, 0);
      // 32 -> 32 directed
      run(1, 32'h01000001, 0, 1, 1, 64'h4B800000, 0, 0);
      run(1, 32'h01000003, 0, 1, 1, 64'h4B800002, 0, 0);
      run(1, 32'h01000003, 0, 0, 1, 64'h4B800001, 0, 0);
      // 32 -> 16 directed (overflow and rounding carry)
      run(2, 32'h00010000, 0, 1, 1, 64'h7C00, 0, 0);
      run(2, 32'h0000FFFF, 0, 1, 1, 64'h7C00, 0, 0);
      run(2, 32'h0000FFFF, 0, 0, 1, 64'h7BFF, 0, 0);
      // Back-pressure for 10 cycles with input noise during conversion
      run(0, 32'h1234, 1, 1, 0, 64'h0, 10, 1);

      // Reset asserted mid-normalisation
      @(negedge clk);
      din = 32'h0001; sm = 1'b0; rm = 1'b1; iv = 3'b001;
      @(posedge clk); #1;
      iv = '0;
      repeat (5) begin @(posedge clk); #1; end
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("async_rst_out_valid", ov[0], 1'b0);
      chk("async_rst_in_ready", ir[0], 1'b1);
      @(negedge clk);
      reset = 1'b1;
      run(0, 32'h0002, 1, 1, 1, 64'h40000000, 0, 0);

      // Randomised operands against the reference model
      for (int k = 0; k < 120; k++) begin
         v = $urandom >> $urandom_range(0, 31);
         run(k % 3, v, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             0, 64'h0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
